// File: rtl/ras_ctrl_if.sv
// Decode-side handshake into the RAS sequencer: op request channel plus the registered pop prediction.
interface ras_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_ret_pc;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_fail;

  modport master (
    output req_valid, req_op, req_ret_pc,
    input  req_ready, pred_valid, pred_pc, pred_fail
  );

  modport slave (
    input  req_valid, req_op, req_ret_pc,
    output req_ready, pred_valid, pred_pc, pred_fail
  );
endinterface

// File: rtl/ras_ctrl.sv
// Call/return op sequencer in front of the RAS: one push or pop per cycle, registered pop prediction.
// Ops issue >=1 cycle after enqueue, prediction 1 cycle after the pop; req_ready drops when full, in FLUSH or on redirect.
module ras_ctrl #(
  parameter int QDEPTH      = 4,
  parameter int FAIL_THRESH = 3
) (
  input  logic        clk,
  input  logic        resetn,
  ras_ctrl_if.slave   dec,
  input  logic        redirect,
  output logic        ras_push,
  output logic        ras_pop,
  output logic        ras_flush,
  output logic [31:0] ras_ret_pc_push,
  input  logic [31:0] ras_ret_pc_pop,
  input  logic        ras_fail,
  output logic        ras_unreliable,
  output logic        busy
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_PUSH2, S_FLUSH} state_t;

  state_t      state, state_nxt;
  logic [1:0]  q_op [QDEPTH];
  logic [31:0] q_pc [QDEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, enq, deq;
  logic [1:0]  head_op;
  logic [31:0] head_pc;
  logic [3:0]  fail_streak;

  // Extra wrap bit on the pointers separates full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_op = q_op[rd_ptr[AW-1:0]];
  assign head_pc = q_pc[rd_ptr[AW-1:0]];

  assign dec.req_ready = !full && (state != S_FLUSH) && !redirect;
  assign enq           = dec.req_valid && dec.req_ready && (dec.req_op != 2'b00);
  assign ras_flush     = (state == S_FLUSH);
  assign busy          = !empty || (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (enq) begin
      q_op[wr_ptr[AW-1:0]] <= dec.req_op;
      q_pc[wr_ptr[AW-1:0]] <= dec.req_ret_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PTR_ONE;
        if (deq) rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Redirect overrides everything: no issue this cycle, and a half-done ret+call is abandoned.
  always_comb begin
    state_nxt       = state;
    ras_push        = 1'b0;
    ras_pop         = 1'b0;
    ras_ret_pc_push = '0;
    deq             = 1'b0;
    if (redirect) begin
      state_nxt = S_FLUSH;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            unique case (head_op)
              2'b01: begin
                ras_push        = 1'b1;
                ras_ret_pc_push = head_pc;
                deq             = 1'b1;
              end
              2'b10: begin
                ras_pop = 1'b1;
                deq     = 1'b1;
              end
              2'b11: begin
                ras_pop   = 1'b1;
                state_nxt = S_PUSH2;
              end
              default: ;
            endcase
          end
        end
        S_PUSH2: begin
          ras_push        = 1'b1;
          ras_ret_pc_push = head_pc;
          deq             = 1'b1;
          state_nxt       = S_IDLE;
        end
        S_FLUSH: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Streak survives redirect on purpose: only a good pop proves the RAS is back in sync.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dec.pred_valid <= 1'b0;
      dec.pred_pc    <= '0;
      dec.pred_fail  <= 1'b0;
      fail_streak    <= '0;
      ras_unreliable <= 1'b0;
    end else begin
      dec.pred_valid <= ras_pop;
      if (ras_pop) begin
        dec.pred_pc   <= ras_ret_pc_pop;
        dec.pred_fail <= ras_fail;
        if (!ras_fail)
          fail_streak <= '0;
        else if (fail_streak != 4'hF)
          fail_streak <= fail_streak + 4'd1;
      end
      ras_unreliable <= (fail_streak >= 4'(FAIL_THRESH));
    end
  end
endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: queue-level reference model checked every cycle, plus literal spot checks.
module tb_ras_ctrl;
  localparam int QDEPTH      = 4;
  localparam int FAIL_THRESH = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        redirect = 1'b0;
  logic        ras_push, ras_pop, ras_flush, ras_unreliable, busy;
  logic [31:0] ras_ret_pc_push;
  logic [31:0] ras_ret_pc_pop = '0;
  logic        ras_fail = 1'b0;

  always #5 clk = ~clk;

  ras_ctrl_if dif ();

  ras_ctrl #(.QDEPTH(QDEPTH), .FAIL_THRESH(FAIL_THRESH)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .dec             (dif),
    .redirect        (redirect),
    .ras_push        (ras_push),
    .ras_pop         (ras_pop),
    .ras_flush       (ras_flush),
    .ras_ret_pc_push (ras_ret_pc_push),
    .ras_ret_pc_pop  (ras_ret_pc_pop),
    .ras_fail        (ras_fail),
    .ras_unreliable  (ras_unreliable),
    .busy            (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending ops as a queue, plus three facts about the controller.
  logic [33:0] mq[$];
  bit          m_owed;
  bit          m_flush;
  bit          m_pv, m_pf, m_unrel;
  logic [31:0] m_ppc;
  int          m_streak;
  bit          e_ready, e_push, e_pop, e_deq, e_busy, e_unrel_nxt;
  logic [31:0] e_data;

  always @(negedge clk) begin
    if (!resetn) begin
      mq.delete();
      m_owed = 0; m_flush = 0; m_pv = 0; m_pf = 0; m_ppc = '0; m_streak = 0; m_unrel = 0;
    end
    e_ready = (mq.size() < QDEPTH) && !m_flush && !redirect;
    e_push = 0; e_pop = 0; e_deq = 0; e_data = '0;
    if (resetn && !redirect && !m_flush) begin
      if (m_owed) begin
        e_push = 1; e_data = mq[0][31:0]; e_deq = 1;
      end else if (mq.size() > 0) begin
        case (mq[0][33:32])
          2'b01: begin e_push = 1; e_data = mq[0][31:0]; e_deq = 1; end
          2'b10: begin e_pop = 1; e_deq = 1; end
          default: e_pop = 1;
        endcase
      end
    end
    e_busy = (mq.size() > 0) || m_owed || m_flush;

    chk("m_req_ready", dif.req_ready, e_ready);
    chk("m_ras_push", ras_push, e_push);
    chk("m_ras_pop", ras_pop, e_pop);
    chk("m_ras_flush", ras_flush, m_flush);
    chk("m_busy", busy, e_busy);
    chk("m_unreliable", ras_unreliable, m_unrel);
    chk("m_pred_valid", dif.pred_valid, m_pv);
    if (e_push) chk("m_push_data", ras_ret_pc_push, e_data);
    if (m_pv) begin
      chk("m_pred_pc", dif.pred_pc, m_ppc);
      chk("m_pred_fail", dif.pred_fail, m_pf);
    end

    if (resetn) begin
      e_unrel_nxt = (m_streak >= FAIL_THRESH);
      m_pv = e_pop;
      if (e_pop) begin
        m_ppc = ras_ret_pc_pop;
        m_pf  = ras_fail;
        m_streak = ras_fail ? ((m_streak == 15) ? 15 : m_streak + 1) : 0;
      end
      m_unrel = e_unrel_nxt;
      if (redirect) begin
        mq.delete(); m_owed = 0; m_flush = 1;
      end else begin
        m_flush = 0;
        if (e_deq) begin
          void'(mq.pop_front());
          m_owed = 0;
        end else if (e_pop) begin
          m_owed = 1;
        end
        if (dif.req_valid && e_ready && dif.req_op != 2'b00)
          mq.push_back({dif.req_op, dif.req_ret_pc});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] pc);
    dif.req_valid  = v;
    dif.req_op     = op;
    dif.req_ret_pc = pc;
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 50; n++) begin
      mid();
      if (!busy) break;
    end
    chk(name, busy, 0);
    step();
  endtask

  int acc;
  bit saw_full;

  initial begin
    drive(0, 2'b00, '0);
    #2 resetn = 1'b0;
    #1;
    chk("rst_req_ready", dif.req_ready, 1);
    chk("rst_push", ras_push, 0);
    chk("rst_pop", ras_pop, 0);
    chk("rst_flush", ras_flush, 0);
    chk("rst_pred_valid", dif.pred_valid, 0);
    chk("rst_unreliable", ras_unreliable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_push_data", ras_ret_pc_push, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Basic call then ret.
    drive(1, 2'b01, 32'h8000_0010); mid(); step();
    drive(1, 2'b10, '0); ras_ret_pc_pop = 32'h8000_0010; ras_fail = 0;
    mid(); chk("basic_push", ras_push, 1); chk("basic_push_data", ras_ret_pc_push, 32'h8000_0010); step();
    drive(0, 2'b00, '0);
    mid(); chk("basic_pop", ras_pop, 1); chk("basic_no_push", ras_push, 0); step();
    mid(); chk("basic_pred_valid", dif.pred_valid, 1); chk("basic_pred_pc", dif.pred_pc, 32'h8000_0010);
    chk("basic_pred_fail", dif.pred_fail, 0); step();

    // Four calls back-to-back: pushes go out in order, one per cycle.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 2'b01, 32'h100 + 32'(4 * i));
      else drive(0, 2'b00, '0);
      mid();
      if (i > 0) begin
        chk("calls_push", ras_push, 1);
        chk("calls_push_data", ras_ret_pc_push, 32'h100 + 32'(4 * (i - 1)));
      end
      step();
    end
    mid(); chk("calls_busy_done", busy, 0); chk("calls_no_push", ras_push, 0); step();

    // Ret+call: pop then push of the same entry.
    drive(1, 2'b11, 32'h2000); mid(); step();
    drive(0, 2'b00, '0); ras_ret_pc_pop = 32'h3333_0000;
    mid(); chk("rc_pop", ras_pop, 1); chk("rc_no_push", ras_push, 0); step();
    mid(); chk("rc_push", ras_push, 1); chk("rc_no_pop", ras_pop, 0);
    chk("rc_push_data", ras_ret_pc_push, 32'h2000); chk("rc_pred_valid", dif.pred_valid, 1);
    chk("rc_pred_pc", dif.pred_pc, 32'h3333_0000); step();
    mid(); chk("rc_busy_done", busy, 0); step();

    // Ret+call ops drain at half rate, so a steady stream fills the queue.
    acc = 0; saw_full = 0;
    for (int c = 0; c < 40 && acc < 8; c++) begin
      drive(1, 2'b11, 32'h4000 + 32'(4 * acc));
      mid();
      if (dif.req_ready) acc++;
      else saw_full = 1;
      step();
    end
    drive(0, 2'b00, '0);
    chk("full_seen", saw_full, 1);
    chk("full_accepted", acc, 8);
    wait_idle("full_drain");

    // Redirect while the second op is due to issue.
    drive(1, 2'b11, 32'h500); mid(); step();
    drive(1, 2'b01, 32'h504); mid(); chk("rd_pop_a", ras_pop, 1); step();
    drive(1, 2'b01, 32'h508); mid(); chk("rd_push_a", ras_ret_pc_push, 32'h500); step();
    drive(0, 2'b00, '0); redirect = 1;
    mid(); chk("rd_gate_push", ras_push, 0); chk("rd_gate_pop", ras_pop, 0); chk("rd_ready", dif.req_ready, 0); step();
    redirect = 0;
    mid(); chk("rd_flush", ras_flush, 1); chk("rd_flush_ready", dif.req_ready, 0); step();
    mid(); chk("rd_flush_once", ras_flush, 0); chk("rd_busy", busy, 0); chk("rd_ready_back", dif.req_ready, 1); step();
    mid(); chk("rd_no_leftover", ras_push, 0); step();

    // Back-to-back redirect holds FLUSH one more cycle.
    redirect = 1; mid(); step();
    mid(); chk("rr_flush1", ras_flush, 1); step();
    redirect = 0;
    mid(); chk("rr_flush2", ras_flush, 1); step();
    mid(); chk("rr_flush_end", ras_flush, 0); step();

    // Redirect in the push half of ret+call drops the push, prior prediction still emits.
    drive(1, 2'b11, 32'h600); mid(); step();
    drive(0, 2'b00, '0); ras_ret_pc_pop = 32'h6666_0000; mid(); step();
    redirect = 1;
    mid(); chk("p2_drop_push", ras_push, 0); chk("p2_pred_valid", dif.pred_valid, 1); step();
    redirect = 0; mid(); step();
    mid(); chk("p2_busy", busy, 0); chk("p2_no_push", ras_push, 0); step();

    // Fail streak reaching the threshold.
    ras_fail = 1; ras_ret_pc_pop = 32'hdead_0000;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(1, 2'b10, '0);
      else drive(0, 2'b00, '0);
      if (c == 4) ras_fail = 0;
      mid();
      if (c == 4) begin
        chk("fs_pred_fail3", dif.pred_fail, 1);
        chk("fs_unrel_early", ras_unreliable, 0);
      end
      if (c == 5) chk("fs_unrel_set", ras_unreliable, 1);
      step();
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1, 2'b10, '0);
      else drive(0, 2'b00, '0);
      mid();
      if (c == 2) begin
        chk("fs_good_pred", dif.pred_fail, 0);
        chk("fs_unrel_hold", ras_unreliable, 1);
      end
      if (c == 3) chk("fs_unrel_clear", ras_unreliable, 0);
      step();
    end

    // Async reset in the push half of ret+call.
    drive(1, 2'b11, 32'h700); mid(); step();
    drive(0, 2'b00, '0); mid(); step();
    #1 chk("ar_in_push2", ras_push, 1);
    resetn = 0;
    #1;
    chk("ar_push", ras_push, 0);
    chk("ar_pop", ras_pop, 0);
    chk("ar_ready", dif.req_ready, 1);
    chk("ar_busy", busy, 0);
    chk("ar_pred_valid", dif.pred_valid, 0);
    mid(); step();
    resetn = 1;
    mid(); chk("ar_no_push1", ras_push, 0); step();
    mid(); chk("ar_no_push2", ras_push, 0); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
